// File: rtl/filt_addr_pkg.sv
// Shared constants and FSM state type for the filter address arbiter and the
// filt_address_calc block it drives.
package filt_addr_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int CALC_LAT_DEF = 1;
  localparam int LAT_CNT_W    = 2;   // wide enough for CALC_LAT up to 3

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/filt_addr_arbiter_rr.sv
// Round-robin picker: the search starts one past the last accepted requester,
// giving a one-hot grant plus its index. last_q moves only when accept_i is high.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       accept_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand_idx = '0;
    // Walk from last+1 around the ring; the first hit wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (accept_i && valid_o) begin
      last_q <= idx_o;
    end
  end

endmodule

// File: rtl/filt_addr_arbiter.sv
// Shares one filt_address_calc between NUM_REQ requesters, one burst at a time.
// Optional FILT_ARB_DONE_CHECK_EN adds a sticky err_o that checks calc_done_i.
//
// state | meaning
// IDLE  | wait for a request, latch round-robin winner and its operands
// LOAD  | grant visible, calculator enable rises on the next edge
// RUN   | enable high, wait CALC_LAT cycles, then one address beat per cycle
// GAP   | enable and grant low for one cycle before accepting again
module filt_addr_arbiter
  import filt_addr_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CALC_LAT = CALC_LAT_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_offset_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_filesize_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic                        addr_valid_o,
  output logic [ADDR_W-1:0]           addr_out_o,
  output logic [NUM_REQ-1:0]          burst_done_o,
  output logic [ADDR_W-1:0]           calc_offset_o,
  output logic [ADDR_W-1:0]           calc_filesize_o,
  output logic                        calc_enable_o,
  input  logic [ADDR_W-1:0]           calc_addr_i,
  input  logic                        calc_done_i
`ifdef FILT_ARB_DONE_CHECK_EN
  ,
  output logic                        err_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   win_oh_q, win_oh_d;
  logic                 gnt_q, gnt_d;
  logic                 zero_q, zero_d;
  logic                 en_q, en_d;
  logic [ADDR_W-1:0]    off_q, off_d;
  logic [ADDR_W-1:0]    fs_q, fs_d;
  logic [LAT_CNT_W-1:0] lat_q, lat_d;
  logic [ADDR_W-1:0]    beat_q, beat_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 accept;
  logic                 beat_fire;
  logic                 last_fire;
  logic [ADDR_W-1:0]    sel_offset;
  logic [ADDR_W-1:0]    sel_filesize;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req_i    (req_i),
    .accept_i (accept),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  assign sel_offset   = req_offset_i[arb_idx*ADDR_W +: ADDR_W];
  assign sel_filesize = req_filesize_i[arb_idx*ADDR_W +: ADDR_W];

  assign beat_fire = (state_q == ST_RUN) && (lat_q == LAT_CNT_W'(CALC_LAT));
  assign last_fire = beat_fire && (beat_q == fs_q - ADDR_W'(1));

  always_comb begin
    state_d      = state_q;
    win_oh_d     = win_oh_q;
    gnt_d        = gnt_q;
    zero_d       = zero_q;
    en_d         = en_q;
    off_d        = off_q;
    fs_d         = fs_q;
    lat_d        = lat_q;
    beat_d       = beat_q;
    accept       = 1'b0;
    addr_valid_o = 1'b0;
    burst_done_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          accept   = 1'b1;
          win_oh_d = arb_gnt;
          off_d    = sel_offset;
          fs_d     = sel_filesize;
          if (sel_filesize == '0) begin
            // Empty burst: skip the calculator, report done from GAP.
            zero_d  = 1'b1;
            gnt_d   = 1'b0;
            state_d = ST_GAP;
          end else begin
            zero_d  = 1'b0;
            gnt_d   = 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        en_d    = 1'b1;
        lat_d   = '0;
        beat_d  = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (beat_fire) begin
          addr_valid_o = 1'b1;
          beat_d       = beat_q + ADDR_W'(1);
          if (last_fire) begin
            burst_done_o = win_oh_q;
            gnt_d        = 1'b0;
            en_d         = 1'b0;
            state_d      = ST_GAP;
          end
        end else begin
          lat_d = lat_q + LAT_CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (zero_q) burst_done_o = win_oh_q;
        zero_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      win_oh_q <= '0;
      gnt_q    <= 1'b0;
      zero_q   <= 1'b0;
      en_q     <= 1'b0;
      off_q    <= '0;
      fs_q     <= '0;
      lat_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_oh_q <= win_oh_d;
      gnt_q    <= gnt_d;
      zero_q   <= zero_d;
      en_q     <= en_d;
      off_q    <= off_d;
      fs_q     <= fs_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
    end
  end

  assign gnt_o           = gnt_q ? win_oh_q : '0;
  assign addr_out_o      = calc_addr_i;
  assign calc_offset_o   = off_q;
  assign calc_filesize_o = fs_q;
  assign calc_enable_o   = en_q;

`ifdef FILT_ARB_DONE_CHECK_EN
  logic err_q, err_d;

  // calc_done_i must be high exactly on the final beat of each burst.
  always_comb begin
    err_d = err_q;
    if (beat_fire && (calc_done_i != last_fire)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_calc_done;
  assign unused_calc_done = calc_done_i;
`endif

endmodule
